// File: rtl/timing_measure_pkg.sv
// Shared types and defaults for the video timing measurement block.
package timing_measure_pkg;

    // Lock-acquisition state machine encoding.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    // Width of coordinate and measurement fields.
    localparam int unsigned DEF_COORD_W        = 10;
    // Cycles without vsync before lock is abandoned.
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;

endpackage : timing_measure_pkg

// File: rtl/timing_measure.sv
// Recovers pixel coordinates from hsync/vsync/de and measures the active
// geometry of each frame; locks once two consecutive consistent frames agree.
module timing_measure
    import timing_measure_pkg::*;
#(
    parameter int unsigned COORD_W        = DEF_COORD_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               de_in,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               de_out,
    output logic [COORD_W-1:0] active_width,
    output logic [COORD_W-1:0] active_height,
    output logic [COORD_W-1:0] h_total,
    output logic               frame_done,
    output logic               locked
);

    localparam logic [COORD_W-1:0] CNT_MAX  = {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] CNT_ONE  = COORD_W'(1);
    localparam int unsigned        TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_ONE  = TMO_W'(1);

    // State
    state_t state;
    state_t state_nxt;

    // Line-level counters
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] x_cnt;
    logic               line_de;
    logic [COORD_W-1:0] last_period;

    // Frame-level accumulators
    logic [COORD_W-1:0] y_cnt;
    logic [COORD_W-1:0] first_w;
    logic               have_first;
    logic               mismatch;
    logic               sat;

    // Vsync watchdog
    logic [TMO_W-1:0]   tmo_cnt;

    // Combinational view of the frame including the current cycle
    logic               de_eff_c;
    logic               line_has_de_c;
    logic               close_line_c;
    logic               x_ovf_c;
    logic               y_ovf_c;
    logic               h_ovf_c;
    logic [COORD_W-1:0] line_w_c;
    logic [COORD_W-1:0] y_fin_c;
    logic [COORD_W-1:0] first_fin_c;
    logic [COORD_W-1:0] period_fin_c;
    logic               mis_fin_c;
    logic               sat_fin_c;
    logic               consistent_c;
    logic               match_c;
    logic               timeout_c;

    // FSM-decoded controls
    logic               frame_close_c;
    logic               pix_blank_c;
    logic               lock_nxt_c;

    // Fold the current cycle's hsync/de into the running frame so a
    // coincident vsync sees the closing line (hsync before frame close).
    always_comb begin
        de_eff_c      = de_in && (state != SEARCH);
        x_ovf_c       = de_eff_c && (x_cnt == CNT_MAX);
        line_w_c      = x_ovf_c ? CNT_MAX : x_cnt + COORD_W'(de_eff_c);
        line_has_de_c = line_de || de_eff_c;
        close_line_c  = hsync_in && line_has_de_c;
        y_ovf_c       = close_line_c && (y_cnt == CNT_MAX);
        h_ovf_c       = !hsync_in && (h_cnt == CNT_MAX);
        y_fin_c       = y_cnt;
        if (close_line_c && !y_ovf_c) begin
            y_fin_c = y_cnt + CNT_ONE;
        end
        first_fin_c   = (close_line_c && !have_first) ? line_w_c : first_w;
        mis_fin_c     = mismatch || (close_line_c && have_first && (line_w_c != first_w));
        period_fin_c  = hsync_in ? h_cnt : last_period;
        sat_fin_c     = sat || x_ovf_c || y_ovf_c || h_ovf_c;
        consistent_c  = !mis_fin_c && !sat_fin_c && (y_fin_c != '0);
        match_c       = (first_fin_c  == active_width)  &&
                        (y_fin_c      == active_height) &&
                        (period_fin_c == h_total);
        timeout_c     = (state != SEARCH) && !vsync_in && (tmo_cnt == TMO_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: advance at each vsync on frame quality, drop on timeout.
    always_comb begin
        state_nxt = state;
        if (timeout_c) begin
            state_nxt = SEARCH;
        end else if (vsync_in) begin
            case (state)
                SEARCH:  state_nxt = MEASURE;
                MEASURE: state_nxt = consistent_c ? VERIFY : MEASURE;
                VERIFY,
                LOCKED:  state_nxt = (consistent_c && match_c) ? LOCKED : MEASURE;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // FSM output decode; the vsync that leaves SEARCH closes no frame.
    always_comb begin
        frame_close_c = 1'b0;
        pix_blank_c   = 1'b0;
        lock_nxt_c    = 1'b0;
        frame_close_c = vsync_in && (state != SEARCH);
        pix_blank_c   = (state == SEARCH) || (state_nxt == SEARCH);
        lock_nxt_c    = (state_nxt == LOCKED);
    end

    // Line counters: h restarts at 1 and x at 0 on every hsync.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt       <= '0;
            x_cnt       <= '0;
            line_de     <= 1'b0;
            last_period <= '0;
        end else if (hsync_in) begin
            h_cnt       <= CNT_ONE;
            x_cnt       <= '0;
            line_de     <= 1'b0;
            last_period <= h_cnt;
        end else begin
            h_cnt       <= h_ovf_c ? h_cnt : h_cnt + CNT_ONE;
            x_cnt       <= line_w_c;
            line_de     <= line_has_de_c;
        end
    end

    // Frame accumulators restart on vsync after the old frame is evaluated.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_cnt      <= '0;
            first_w    <= '0;
            have_first <= 1'b0;
            mismatch   <= 1'b0;
            sat        <= 1'b0;
        end else if (vsync_in) begin
            y_cnt      <= '0;
            first_w    <= '0;
            have_first <= 1'b0;
            mismatch   <= 1'b0;
            sat        <= 1'b0;
        end else begin
            y_cnt      <= y_fin_c;
            first_w    <= first_fin_c;
            have_first <= have_first || close_line_c;
            mismatch   <= mis_fin_c;
            sat        <= sat_fin_c;
        end
    end

    // Cycles since the last vsync while tracking a signal.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (vsync_in || (state == SEARCH)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
        end
    end

    // Pixel coordinate outputs, one cycle behind de_in; blanked while searching.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_out  <= '0;
            y_out  <= '0;
            de_out <= 1'b0;
        end else if (pix_blank_c) begin
            x_out  <= '0;
            y_out  <= '0;
            de_out <= 1'b0;
        end else begin
            de_out <= de_in;
            if (de_in) begin
                x_out <= x_cnt;
                y_out <= y_cnt;
            end
        end
    end

    // Measurement registers update together with the frame_done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_width  <= '0;
            active_height <= '0;
            h_total       <= '0;
            frame_done    <= 1'b0;
            locked        <= 1'b0;
        end else begin
            frame_done <= frame_close_c;
            locked     <= lock_nxt_c;
            if (frame_close_c) begin
                active_width  <= first_fin_c;
                active_height <= y_fin_c;
                h_total       <= period_fin_c;
            end
        end
    end

endmodule : timing_measure

// File: tb/tb_timing_measure.sv
// Directed bench for timing_measure: lock sequence, line disturbance,
// saturation, coincident syncs, vsync timeout and mid-frame reset.
module tb_timing_measure;
    import timing_measure_pkg::*;

    localparam int unsigned CW = 10;

    logic          clk;
    logic          reset;
    logic          hsync_in;
    logic          vsync_in;
    logic          de_in;
    logic [CW-1:0] x_out, y_out, active_width, active_height, h_total;
    logic          de_out, frame_done, locked;
    logic [CW-1:0] t_x, t_y, t_aw, t_ah, t_ht;
    logic          t_de, t_fd, t_lk;

    int n_checks;
    int n_errors;
    int fd_count;

    logic [31:0] snap_fd, snap_fd2, snap_lk, snap_st, snap_w, snap_h, snap_ht;
    logic [31:0] snap_lk_t, snap_x, snap_y;

    timing_measure #(.COORD_W(CW), .TIMEOUT_CYCLES(1048576)) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .x_out(x_out), .y_out(y_out), .de_out(de_out),
        .active_width(active_width), .active_height(active_height), .h_total(h_total),
        .frame_done(frame_done), .locked(locked)
    );

    timing_measure #(.COORD_W(CW), .TIMEOUT_CYCLES(1000)) dut_tmo (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .x_out(t_x), .y_out(t_y), .de_out(t_de),
        .active_width(t_aw), .active_height(t_ah), .h_total(t_ht),
        .frame_done(t_fd), .locked(t_lk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, wait for the edge, settle before sampling.
    task automatic tick(input logic hs, input logic vs, input logic de);
        hsync_in = hs;
        vsync_in = vs;
        de_in    = de;
        @(posedge clk);
        #1;
        if (frame_done) fd_count++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // One frame: vblank lines first (vsync with the first hsync), then active
    // lines; each line is hsync, blanking, then de. Line period is w+hb.
    task automatic send_frame(input int w, input int hb, input int h, input int vb, input int short_idx);
        for (int l = 0; l < vb + h; l++) begin
            int dl;
            int bl;
            dl = 0;
            if (l >= vb) dl = ((l - vb) == short_idx) ? w - 1 : w;
            bl = w + hb - dl;
            tick(1'b1, (l == 0), 1'b0);
            if (l == 0) begin
                snap_fd   = 32'(frame_done);
                snap_lk   = 32'(locked);
                snap_st   = 32'(dut.state);
                snap_w    = 32'(active_width);
                snap_h    = 32'(active_height);
                snap_ht   = 32'(h_total);
                snap_lk_t = 32'(t_lk);
            end
            for (int i = 1; i < bl; i++) begin
                tick(1'b0, 1'b0, 1'b0);
                if (l == 0 && i == 1) snap_fd2 = 32'(frame_done);
            end
            for (int i = 0; i < dl; i++) tick(1'b0, 1'b0, 1'b1);
        end
        snap_x = 32'(x_out);
        snap_y = 32'(y_out);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        fd_count = 0;
        reset    = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        de_in    = 1'b0;

        // Reset state
        do_reset();
        check("rst_xy",    32'({x_out, y_out}), 32'd0);
        check("rst_meas",  32'({active_width, active_height, h_total}), 32'd0);
        check("rst_flags", 32'({de_out, frame_done, locked}), 32'd0);
        check("rst_state", 32'(dut.state), 32'(SEARCH));

        // Standard timing 267 wide, hblank 5, vblank 6, 16 active lines
        fd_count = 0;
        send_frame(267, 5, 16, 6, -1);
        check("f1_no_done",  snap_fd, 32'd0);
        check("f1_state",    snap_st, 32'(MEASURE));
        send_frame(267, 5, 16, 6, -1);
        check("f2_done",     snap_fd, 32'd1);
        check("f2_pulse",    snap_fd2, 32'd0);
        check("f2_width",    snap_w, 32'd267);
        check("f2_height",   snap_h, 32'd16);
        check("f2_htotal",   snap_ht, 32'd272);
        check("f2_state",    snap_st, 32'(VERIFY));
        send_frame(267, 5, 16, 6, -1);
        check("f3_done",     snap_fd, 32'd1);
        check("f3_locked",   snap_lk, 32'd1);
        check("f3_width",    snap_w, 32'd267);
        check("done_count",  32'(fd_count), 32'd2);
        check("f3_last_x",   snap_x, 32'd266);
        check("f3_last_y",   snap_y, 32'd15);

        // One shortened line while locked, then relock
        send_frame(267, 5, 16, 6, 5);
        check("f4_locked",   snap_lk, 32'd1);
        send_frame(267, 5, 16, 6, -1);
        check("bad_locked",  snap_lk, 32'd0);
        check("bad_state",   snap_st, 32'(MEASURE));
        check("bad_done",    snap_fd, 32'd1);
        send_frame(267, 5, 16, 6, -1);
        check("re1_state",   snap_st, 32'(VERIFY));
        check("re1_locked",  snap_lk, 32'd0);
        send_frame(267, 5, 16, 6, -1);
        check("re2_state",   snap_st, 32'(LOCKED));
        check("re2_locked",  snap_lk, 32'd1);

        // Continuous de: x saturates, frame rejected
        do_reset();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) tick(1'b0, 1'b0, 1'b1);
        check("sat_x_999",   32'(x_out), 32'd999);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 1'b1);
        check("sat_x_max",   32'(x_out), 32'd1023);
        check("sat_de_out",  32'(de_out), 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("sat_done",    32'(frame_done), 32'd1);
        check("sat_state",   32'(dut.state), 32'(MEASURE));
        check("sat_locked",  32'(locked), 32'd0);
        check("sat_width",   32'(active_width), 32'd1023);
        check("sat_height",  32'(active_height), 32'd1);

        // de coincident with hsync, and hsync+vsync+de closing the frame
        do_reset();
        tick(1'b1, 1'b1, 1'b0);
        check("co_first_vs", 32'(frame_done), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("co_hs_x",     32'(x_out), 32'd3);
        check("co_hs_y",     32'(y_out), 32'd0);
        tick(1'b0, 1'b0, 1'b1);
        check("co_restart_x", 32'(x_out), 32'd0);
        check("co_restart_y", 32'(y_out), 32'd1);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        check("co_done",     32'(frame_done), 32'd1);
        check("co_width",    32'(active_width), 32'd4);
        check("co_height",   32'(active_height), 32'd2);
        check("co_htotal",   32'(h_total), 32'd6);
        check("co_state",    32'(dut.state), 32'(VERIFY));

        // Vsync timeout on the 1000-cycle instance (18-cycle frames)
        do_reset();
        send_frame(4, 2, 2, 1, -1);
        send_frame(4, 2, 2, 1, -1);
        send_frame(4, 2, 2, 1, -1);
        check("tmo_locked0", snap_lk_t, 32'd1);
        for (int i = 0; i < 979; i++) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        check("tmo_999_lk",  32'(t_lk), 32'd1);
        check("tmo_999_de",  32'(t_de), 32'd1);
        tick(1'b0, 1'b0, 1'b1);
        check("tmo_1000_lk", 32'(t_lk), 32'd0);
        check("tmo_state",   32'(dut_tmo.state), 32'(SEARCH));
        check("tmo_de_out",  32'(t_de), 32'd0);
        check("tmo_hold",    32'({t_aw, t_ah, t_ht}), 32'({10'd4, 10'd2, 10'd6}));

        // Reset mid-line while locked
        do_reset();
        send_frame(4, 2, 2, 1, -1);
        send_frame(4, 2, 2, 1, -1);
        send_frame(4, 2, 2, 1, -1);
        check("mr_locked",   snap_lk, 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        check("mr_pre_x",    32'(x_out), 32'd2);
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        check("mr_xy",       32'({x_out, y_out}), 32'd0);
        check("mr_meas",     32'({active_width, active_height, h_total}), 32'd0);
        check("mr_flags",    32'({de_out, frame_done, locked}), 32'd0);
        check("mr_state",    32'(dut.state), 32'(SEARCH));
        fd_count = 0;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        send_frame(4, 2, 2, 1, -1);
        check("mr_vs1_done", snap_fd, 32'd0);
        send_frame(4, 2, 2, 1, -1);
        check("mr_vs2_done", snap_fd, 32'd1);
        check("mr_vs2_meas", 32'({snap_w[9:0], snap_h[9:0], snap_ht[9:0]}), 32'({10'd4, 10'd2, 10'd6}));
        check("mr_count",    32'(fd_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_timing_measure

// File: doc/timing_measure.md
TIMING_MEASURE -- requirements
Module: timing_measure

Interface
REQ-001 SHALL have parameter COORD_W, default 10, giving the width of coordinate and measurement fields.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, giving the cycles without vsync before lock is dropped.
REQ-003 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: hsync_in  input  1  one-cycle line-start pulse.
REQ-006 Port: vsync_in  input  1  one-cycle frame-start pulse.
REQ-007 Port: de_in  input  1  active-pixel qualifier.
REQ-008 Port: x_out  output  COORD_W  recovered pixel column.
REQ-009 Port: y_out  output  COORD_W  recovered active line.
REQ-010 Port: de_out  output  1  x_out/y_out valid.
REQ-011 Port: active_width  output  COORD_W  de cycles per active line, last completed frame.
REQ-012 Port: active_height  output  COORD_W  active lines, last completed frame.
REQ-013 Port: h_total  output  COORD_W  clk cycles between the last two hsync pulses of the last completed frame.
REQ-014 Port: frame_done  output  1  one-cycle pulse when the measurement registers update.
REQ-015 Port: locked  output  1  stable timing detected.

Function
REQ-016 SHALL implement states SEARCH, MEASURE, VERIFY and LOCKED.
REQ-017 SEARCH: SHALL ignore de_in, hold de_out=0, and go to MEASURE on vsync_in.
REQ-018 MEASURE: SHALL go to VERIFY on the next vsync_in if the frame was consistent (REQ-024), else stay in MEASURE.
REQ-019 VERIFY: SHALL go to LOCKED on the next vsync_in if the frame is consistent and width, height and h_total equal the stored frame, else go to MEASURE.
REQ-020 LOCKED: SHALL apply the same check as VERIFY at every vsync_in and go to MEASURE on any failure.
REQ-021 Outside SEARCH: x_out/y_out/de_out SHALL be registered, with 1-cycle latency from de_in.
REQ-022 Outside SEARCH: x_out SHALL be the count of de_in-high cycles since the last hsync_in.
REQ-023 Outside SEARCH: y_out SHALL be the count of lines containing de since the last vsync_in.
REQ-024 A frame SHALL be consistent only if every active line's de count equals the first active line's de count and active_height > 0.
REQ-025 Line closure on hsync_in:
- the h cycle counter restarts at 1;
- the line counter increments if that line had de.
REQ-026 If de_in and hsync_in are high in the same cycle, de SHALL count toward the closing line, and x restarts from 0 on the next cycle.
REQ-027 If vsync_in and hsync_in are high in the same cycle, hsync SHALL be processed first, then the frame closes.
REQ-028 At frame close, measurements SHALL latch and frame_done SHALL pulse one cycle later; the first vsync from SEARCH closes no frame and gives no pulse.
REQ-029 All counters SHALL saturate at 2^COORD_W-1, and a saturated frame SHALL be inconsistent.
REQ-030 locked SHALL equal (state==LOCKED), registered.
REQ-031 If TIMEOUT_CYCLES elapse with no vsync_in, the block SHALL enter SEARCH, clear locked, and hold measurements.

Reset
REQ-032 On reset: state=SEARCH; all outputs and counters 0.
REQ-033 Reset asserted mid-frame SHALL discard partial counts; the first frame_done SHALL follow the second post-reset vsync.

Structure
REQ-034 Package timing_measure_pkg SHALL hold the state enum, the default COORD_W and the default TIMEOUT_CYCLES.
REQ-035 The block SHALL be a single flat module with no sub-module.

Verification
REQ-036 Feed the standard generator timing (267 wide, 240 high, HBLANK_LEN 5, VBLANK_LEN 6) for 3 frames -> frame_done after frames 1 and 2 with active_width=267, active_height=240, h_total=272; locked=1 after the frame-3 vsync.
REQ-037 While locked, shorten one line to 266 de cycles -> that frame closes inconsistent, locked=0, state=MEASURE, relock 2 frames later.
REQ-038 Hold de_in=1 continuously for 1100 cycles -> x_out saturates at 1023 and the frame is inconsistent, with no lock.
REQ-039 Stop vsync_in for TIMEOUT_CYCLES (bench override 1000) -> locked=0 at cycle 1000, state=SEARCH, de_out=0.
REQ-040 Assert reset mid-line while locked -> all outputs 0 next cycle; the first frame_done follows the second subsequent vsync.
REQ-041 Drive hsync_in, vsync_in and de_in together -> the de is counted in the closing line, then the frame closes in that cycle.
